// File: rtl/prog_loader_pkg.sv
// Shared state and status encodings for the program loader.
package prog_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LOAD    = 3'd1;
  localparam state_t S_RELEASE = 3'd2;
  localparam state_t S_RUN     = 3'd3;
  localparam state_t S_HALT    = 3'd4;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_OVF  = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

endpackage

// File: rtl/prog_loader_run_timer.sv
// 16-bit saturating run-cycle counter with clear/enable and a watchdog hit flag.
module run_timer #(
  parameter int unsigned WDOG = 65535
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] count_o,
  output logic        hit_o
);

  localparam logic [16:0] LIMIT = {1'b0, WDOG[15:0]};

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && ({1'b0, count_q} < LIMIT)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the enabled cycle whose increment lands the count on the limit.
  assign hit_o   = en_i && (({1'b0, count_q} + 17'd1) >= LIMIT);
  assign count_o = count_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, releases the core from reset,
// then supervises the run until done or watchdog timeout.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned D         = 12,
  parameter int unsigned W         = 9,
  parameter int unsigned MAX_WORDS = 4096,
  parameter int unsigned WDOG      = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  input  logic         s_last,
  output logic         s_ready,
  output logic         im_wr_en,
  output logic [D-1:0] im_addr,
  output logic [W-1:0] im_data,
  output logic         core_reset,
  input  logic         core_done,
  output logic         busy,
  output logic [1:0]   status,
  output logic [15:0]  run_cycles,
  output logic [D:0]   word_count
);

  localparam int unsigned LAST_IDX_I = MAX_WORDS - 1;
  localparam logic [D:0]  LAST_IDX   = LAST_IDX_I[D:0];

  state_t       state_q, state_d;
  logic [D:0]   wc_q, wc_d;
  logic [1:0]   status_q, status_d;
  logic         rel_q, rel_d;
  logic         wr_en_q;
  logic [D-1:0] addr_q;
  logic [W-1:0] data_q;
  logic         hs;
  logic         launch;
  logic         tmr_hit;

  assign s_ready = (state_q == S_LOAD);
  assign hs      = s_valid & s_ready;
  assign launch  = start && ((state_q == S_IDLE) || (state_q == S_HALT));

  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    status_d = status_q;
    rel_d    = rel_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (launch) begin
          state_d  = S_LOAD;
          wc_d     = '0;
          status_d = ST_NONE;
        end
      end
      S_LOAD: begin
        if (hs) begin
          wc_d = wc_q + (D+1)'(1);
          if (s_last) begin
            state_d = S_RELEASE;
            rel_d   = 1'b0;
          end else if (wc_q == LAST_IDX) begin
            state_d  = S_HALT;
            status_d = ST_OVF;
          end
        end
      end
      S_RELEASE: begin
        // Two cycles in reset so the final memory write lands first.
        rel_d = 1'b1;
        if (rel_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (core_done) begin
          state_d  = S_HALT;
          status_d = ST_PASS;
        end else if (tmr_hit) begin
          state_d  = S_HALT;
          status_d = ST_TMO;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wc_q     <= '0;
      status_q <= ST_NONE;
      rel_q    <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wc_q     <= wc_d;
      status_q <= status_d;
      rel_q    <= rel_d;
      wr_en_q  <= hs;
      if (hs) begin
        addr_q <= wc_q[D-1:0];
        data_q <= s_data;
      end
    end
  end

  run_timer #(
    .WDOG(WDOG)
  ) u_run_timer (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (launch),
    .en_i   (state_q == S_RUN),
    .count_o(run_cycles),
    .hit_o  (tmr_hit)
  );

  assign im_wr_en   = wr_en_q;
  assign im_addr    = addr_q;
  assign im_data    = data_q;
  assign core_reset = (state_q != S_RUN);
  assign busy       = (state_q == S_LOAD) || (state_q == S_RELEASE) || (state_q == S_RUN);
  assign status     = status_q;
  assign word_count = wc_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter D, default 12, program-counter / instruction-address width.
REQ-002 Parameter W, default 9, machine-code word width.
REQ-003 Parameter MAX_WORDS, default 4096, instruction store depth (must be ≤ 2**D).
REQ-004 Parameter WDOG, default 65535, run-cycle limit before timeout.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low (0 = reset) block reset.
REQ-007 start  in  1  one-cycle request to begin a load/run sequence.
REQ-008 s_valid  in  1  upstream word valid.
REQ-009 s_data  in  W  upstream machine-code word.
REQ-010 s_last  in  1  marks final word of program, qualified by s_valid.
REQ-011 s_ready  out  1  loader accepts word this cycle.
REQ-012 im_wr_en  out  1  instruction-memory write strobe.
REQ-013 im_addr  out  D  instruction-memory write address.
REQ-014 im_data  out  W  instruction-memory write data.
REQ-015 core_reset  out  1  active-high reset to downstream core.
REQ-016 core_done  in  1  downstream core finished flag.
REQ-017 busy  out  1  high in LOAD, RELEASE, RUN.
REQ-018 status  out  2  00 none, 01 pass, 10 overflow, 11 timeout.
REQ-019 run_cycles  out  16  cycles spent in RUN, saturating at WDOG.
REQ-020 word_count  out  D+1  words written in last load.

Function
REQ-021 FSM states: IDLE, LOAD, RELEASE, RUN, HALT.
REQ-022 IDLE: s_ready=0, core_reset=1; start -> LOAD next cycle, word_count, run_cycles, status cleared to 0.
REQ-023 LOAD: s_ready=1; handshake = s_valid & s_ready.
REQ-024 Each handshake registers im_wr_en=1, im_addr=word_count, im_data=s_data in the next cycle (1-cycle latency); word_count increments.
REQ-025 No handshake in a cycle -> im_wr_en=0 next cycle; im_addr/im_data hold.
REQ-026 Handshake with s_last=1 -> RELEASE; s_ready=0 from next cycle.
REQ-027 Handshake at word_count=MAX_WORDS-1 with s_last=0 -> word still written, status=10, HALT.
REQ-028 Handshake at word_count=MAX_WORDS-1 with s_last=1 -> normal RELEASE, no overflow.
REQ-029 RELEASE: core_reset held 1 for exactly 2 cycles (lets final write land), then RUN.
REQ-030 RUN: core_reset=0; run_cycles increments every cycle.
REQ-031 RUN with core_done=1 -> status=01, HALT; done sampled before timeout check (simultaneous -> pass).
REQ-032 RUN with run_cycles reaching WDOG -> status=11, HALT; run_cycles saturates.
REQ-033 HALT: core_reset=1, status/word_count/run_cycles held; start -> LOAD with counters cleared.
REQ-034 start ignored in LOAD, RELEASE, RUN.
REQ-035 core_done ignored outside RUN.

Reset
REQ-036 reset=0 at a clock edge: state IDLE, s_ready=0, im_wr_en=0, im_addr=0, im_data=0, core_reset=1, busy=0, status=00, run_cycles=0, word_count=0.
REQ-037 Reset mid-LOAD or mid-RUN aborts immediately; no write strobe issued the cycle after reset.

Structure
REQ-038 Package prog_loader_pkg holds the state enum and status encodings (ST_NONE, ST_PASS, ST_OVF, ST_TMO).
REQ-039 One sub-module run_timer: 16-bit saturating counter with clear/enable, WDOG compare output.

Verification
REQ-040 Load 3 words (0x1A0,0x055,0x1FF, last on third) -> im writes at addr 0,1,2 one cycle after each handshake, word_count=3, core_reset falls 2 cycles after last.
REQ-041 s_valid gaps during LOAD (valid 1,0,0,1) -> exactly 2 writes, consecutive addresses, no spurious strobes.
REQ-042 MAX_WORDS=4, send 4 words without s_last -> 4 writes, status=10, HALT, core_reset stays 1.
REQ-043 WDOG=10, core_done never asserted -> status=11 after 10 RUN cycles, run_cycles=10.
REQ-044 core_done asserted on 5th RUN cycle -> status=01, run_cycles=5; then start reloads with counters cleared.
REQ-045 reset=0 during 2nd word of LOAD -> all outputs at reset values next cycle, IDLE, start required to resume.
